// File: rtl/axrm_seq_divider.sv
// axrm_seq_divider: sequential radix-2 restoring divider.
// Divides a DW-bit dividend by a VW-bit divisor, producing one quotient bit per
// clock. Operands are latched on acceptance, so upstream may change them freely
// once in_ready drops. A zero divisor completes immediately with the saturated
// quotient, the dividend's low bits as remainder, and div_by_zero set.
// DW must be >= VW so the divide-by-zero remainder can be taken from the dividend.

module axrm_seq_divider #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    state_t        state;
    state_t        state_nxt;

    // acc starts as the dividend and fills with quotient bits from the right.
    logic [DW-1:0] acc;
    logic [VW-1:0] prem;
    logic [VW-1:0] dvsr;
    logic [CW-1:0] cnt;
    logic          dbz;

    logic [VW:0]   trial;
    logic [VW-1:0] diff;
    logic          ge;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    // NOTE: the default assignment first guarantees no latch is inferred on
    // paths that do not change state.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:  if (cnt == LAST_ITER) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit and try to subtract.
    // When trial >= divisor the true difference is below the divisor, so it
    // fits VW bits and the low-bit subtraction gives it exactly.
    always_comb begin
        trial = {prem, acc[DW-1]};
        ge    = (trial >= {1'b0, dvsr});
        diff  = trial[VW-1:0] - dvsr;
    end

    // Datapath: operand capture on acceptance, one iteration per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            prem <= '0;
            dvsr <= '0;
            cnt  <= '0;
            dbz  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvsr <= divisor;
                        cnt  <= '0;
                        if (divisor == '0) begin
                            acc  <= '1;
                            prem <= dividend[VW-1:0];
                            dbz  <= 1'b1;
                        end else begin
                            acc  <= dividend;
                            prem <= '0;
                            dbz  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    prem <= ge ? diff : trial[VW-1:0];
                    acc  <= {acc[DW-2:0], ge};
                    cnt  <= cnt + CW'(1);
                end
                default: ; // DONE and idle cycles hold the result
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = acc;
    assign remainder   = prem;
    assign div_by_zero = dbz;

endmodule

// File: tb/tb_axrm_seq_divider.sv
// tb_axrm_seq_divider: directed and randomized checks of axrm_seq_divider
// against an arithmetic reference (/ and %), including latency, backpressure,
// mid-operation reset and result accounting.

module tb_axrm_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    int n_in  = 0;
    int n_out = 0;

    axrm_seq_divider #(.DW(16), .VW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, saturated result for a zero divisor.
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic z);
        if (b == 8'd0) begin
            q = 16'hFFFF;
            r = a[7:0];
            z = 1'b1;
        end else begin
            logic [15:0] r16;
            q   = a / {8'd0, b};
            r16 = a % {8'd0, b};
            r   = r16[7:0];
            z   = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and return just after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_before_send", in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        n_in++;
    endtask

    // Count edges after acceptance until out_valid; optionally scramble inputs
    // meanwhile. Tracks whether in_ready was ever seen high during the wait.
    task automatic wait_valid(input bit scramble, output int lat, output bit ready_seen);
        lat = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            if (scramble) begin
                in_valid = 1'($urandom_range(0, 1));
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        if (out_valid) n_out++;
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        model(a, b, eq, er, ez);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
    endtask

    // Accept the result; the block must return to IDLE with no repeat.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_no_dup"}, out_valid, 0);
        check({tag, "_idle"}, in_ready, 1);
    endtask

    // Latency counts edges after the accepting edge: 16 for a real divide,
    // 0 for a zero divisor (result visible in the cycle after acceptance).
    task automatic directed(input string tag, input logic [15:0] a, input logic [7:0] b);
        int lat;
        bit ready_seen;
        send(a, b);
        wait_valid(1'b0, lat, ready_seen);
        check({tag, "_latency"}, lat, (b == 8'd0) ? 0 : 16);
        check({tag, "_ready_low_run"}, ready_seen, 0);
        check_result(tag, a, b);
        drain(tag);
    endtask

    initial begin
        int lat;
        bit ready_seen;
        bit stale;

        // Reset state while rst is held.
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        tick();
        rst = 1'b0;
        tick();

        directed("sq225", 16'd50625, 8'd225);
        directed("d1000_7", 16'd1000, 8'd7);
        directed("max_by_1", 16'd65535, 8'd1);
        directed("max_by_255", 16'd65535, 8'd255);
        directed("div_zero", 16'h1234, 8'd0);

        // Backpressure: result held for 10 cycles, then back-to-back op.
        send(16'd1000, 8'd7);
        wait_valid(1'b0, lat, ready_seen);
        check("bp_latency", lat, 16);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_result("bp_hold", 16'd1000, 8'd7);
            check("bp_in_ready_low", in_ready, 0);
        end
        drain("bp");
        directed("bp_next", 16'd40000, 8'd123);

        // Reset at RUN iteration 8 while inputs toggle.
        send(16'd60000, 8'd3);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = 16'($urandom);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_quotient", quotient, 0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        check("abort_no_stale_valid", stale, 0);
        n_in--; // the aborted operation produces no result
        directed("after_abort", 16'd300, 8'd12);

        // Random sweep with scrambled inputs during RUN and random out_ready gaps.
        for (int k = 0; k < 2000; k++) begin
            logic [15:0] a;
            logic [7:0]  b;
            int gap;
            a = 16'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 4));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            send(a, b);
            wait_valid(1'b1, lat, ready_seen);
            check("rnd_latency", lat, (b == 8'd0) ? 0 : 16);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            check_result("rnd", a, b);
            if (b != 8'd0) begin
                int unsigned recon;
                recon = int'(quotient) * int'(b) + int'(remainder);
                check("rnd_identity", recon, {16'd0, a});
                check("rnd_rem_lt_div", (remainder < b), 1);
            end
            drain("rnd");
        end
        check("results_vs_ops", n_out, n_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
